mod_mem: RTL and testbench
==========================

// Module: mod_mem
// PURPOSE
//   Memory stage of the 16-bit 5-stage pipeline; sits directly downstream of the execution stage.
//   Holds the EX/MEM pipeline register and drives a variable-latency data memory via req/ready.
//   Stalls the upstream pipeline while an access is outstanding, and produces the MEM/WB register.
//   Supplies forward_DstData_MEM plus its destination tag to the EX forwarding mux.
// PARAMETERS
//   MAX_WAIT  255  wait cycles tolerated per access before timeout error (1..255)
// PORTS
//   clk                  in   1   system clock; one clock, all state on rising edge
//   rst                  in   1   reset; asynchronous, active-low (0 = reset)
//   in_valid             in   1   EX stage result valid (0 = bubble)
//   aluout               in   16  EX result / effective address
//   store_data           in   16  data for SW (forwarded SrcData2)
//   dstreg               in   4   destination register
//   regwrite             in   1   instruction writes register file
//   memread              in   1   load
//   memwrite             in   1   store
//   stall_out            out  1   freeze PC/IF/ID/EX and EX/MEM capture
//   mem_req              out  1   data memory request
//   mem_we               out  1   1 = write, 0 = read (valid with mem_req)
//   mem_addr             out  16  memory address
//   mem_wdata            out  16  store data
//   mem_ready            in   1   access complete this cycle; mem_rdata valid if read
//   mem_rdata            in   16  load data
//   forward_DstData_MEM  out  16  EX/MEM ALU result for forwarding
//   fwd_dstreg           out  4   EX/MEM destination tag
//   fwd_regwrite         out  1   EX/MEM valid & regwrite & !memread
//   wb_valid             out  1   MEM/WB holds a real instruction
//   wb_DstData           out  16  write-back data
//   wb_dstreg            out  4   write-back register
//   wb_regwrite          out  1   write-back enable (wb_valid & regwrite)
//   mem_err              out  1   sticky timeout error
// BEHAVIOUR
//   Reset (rst=0, async): EX/MEM and MEM/WB regs cleared; all outputs 0; state IDLE; wait_cnt 0.
//   EX/MEM capture: at each edge with stall_out=0, latch inputs; in_valid=0 loads a bubble (all ctrl 0).
//   Stalled (stall_out=1): EX/MEM holds its value.
//   mem op = EX/MEM valid & (memread|memwrite); memwrite has priority if both set (write, DstData=aluout).
//   mem_req = mem op & state!=ERR; mem_addr=aluout, mem_wdata=store_data, mem_we=memwrite (combinational from EX/MEM).
//   FSM states IDLE, WAIT, ERR:
//     IDLE: mem op & !mem_ready -> WAIT, wait_cnt<=1. mem op & mem_ready -> zero-wait completion, stay IDLE.
//     WAIT: mem_ready -> IDLE, wait_cnt<=0. Else if wait_cnt==MAX_WAIT -> ERR. Else wait_cnt+1.
//     ERR: absorbing until reset; mem_req=0, stall_out=1, mem_err=1.
//     mem_ready and timeout in the same cycle: ready wins.
//   stall_out = (mem op & !mem_ready) | state==ERR (combinational; drops in the completion cycle).
//   mem_ready while mem_req=0 is ignored.
//   MEM/WB capture every edge:
//     stall_out=1 -> bubble (wb_valid=0, wb_regwrite=0, data/tag 0).
//     else copy EX/MEM; wb_DstData = (memread & !memwrite) ? mem_rdata : aluout.
//   Latency: non-memory op in EX/MEM at cycle n -> on wb_* at n+1. Access completing after k wait cycles -> wb at n+k+1.
//   Forwarding outputs come straight from EX/MEM; load data is never forwarded here (load-use handled by hazard unit).
//   Reset mid-access: mem_req falls immediately; in-flight access abandoned; no write-back.
// TESTING
//   ADD: aluout=0x1234, dstreg=3, regwrite=1 -> next cycle wb_DstData=0x1234, wb_dstreg=3, wb_regwrite=1, stall_out=0 throughout.
//   LW, zero-wait: addr 0x0040, mem_ready=1 same cycle, rdata 0xBEEF -> no stall; wb_DstData=0xBEEF one cycle later.
//   SW, 3-cycle wait: addr 0x0010, data 0x00AA -> mem_req/mem_we held with stable addr/data; stall_out=1 for 3 cycles; wb_regwrite=0; EX/MEM unchanged.
//   Timeout: MAX_WAIT=4, load, mem_ready never asserted -> ERR after 4 wait cycles; mem_err=1, mem_req=0, stall_out stuck at 1.
//   Reset during WAIT: rst=0 mid-stall -> all outputs 0 asynchronously; after release, next ADD flows normally.
//   Bubble plus stray ready: in_valid=0 with mem_ready=1 pulses -> mem_req=0, wb_valid=0, no state change.

Source files
------------

// File: rtl/mod_mem.sv
// Memory stage: EX/MEM register, variable-latency data memory handshake,
// pipeline stall generation and MEM/WB register.
module mod_mem #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] aluout,
    input  logic [15:0] store_data,
    input  logic [3:0]  dstreg,
    input  logic        regwrite,
    input  logic        memread,
    input  logic        memwrite,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] forward_DstData_MEM,
    output logic [3:0]  fwd_dstreg,
    output logic        fwd_regwrite,
    output logic        wb_valid,
    output logic [15:0] wb_DstData,
    output logic [3:0]  wb_dstreg,
    output logic        wb_regwrite,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        ex_valid_q, ex_valid_d;
    logic [15:0] ex_aluout_q, ex_aluout_d;
    logic [15:0] ex_store_q, ex_store_d;
    logic [3:0]  ex_dst_q, ex_dst_d;
    logic        ex_rw_q, ex_rw_d;
    logic        ex_mr_q, ex_mr_d;
    logic        ex_mw_q, ex_mw_d;

    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [3:0]  wb_dst_q, wb_dst_d;
    logic        wb_rw_q, wb_rw_d;

    logic        mem_op;
    logic        in_err;

    always_comb begin
        mem_op    = ex_valid_q & (ex_mr_q | ex_mw_q);
        in_err    = (state_q == ERR);
        stall_out = (mem_op & ~mem_ready) | in_err;
        mem_req   = mem_op & ~in_err;
        mem_we    = mem_req & ex_mw_q;
        mem_addr  = ex_aluout_q;
        mem_wdata = ex_store_q;
        mem_err   = in_err;
    end

    // Forwarding never carries load data; load-use is resolved upstream.
    always_comb begin
        forward_DstData_MEM = ex_aluout_q;
        fwd_dstreg          = ex_dst_q;
        fwd_regwrite        = ex_valid_q & ex_rw_q & ~ex_mr_q;
        wb_valid            = wb_valid_q;
        wb_DstData          = wb_data_q;
        wb_dstreg           = wb_dst_q;
        wb_regwrite         = wb_rw_q;
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_aluout_d = ex_aluout_q;
        ex_store_d  = ex_store_q;
        ex_dst_d    = ex_dst_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        ex_mw_d     = ex_mw_q;
        if (!stall_out) begin
            ex_valid_d  = in_valid;
            ex_aluout_d = in_valid ? aluout : 16'h0000;
            ex_store_d  = in_valid ? store_data : 16'h0000;
            ex_dst_d    = in_valid ? dstreg : 4'h0;
            ex_rw_d     = in_valid & regwrite;
            ex_mr_d     = in_valid & memread;
            ex_mw_d     = in_valid & memwrite;
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_data_d  = 16'h0000;
        wb_dst_d   = 4'h0;
        wb_rw_d    = 1'b0;
        if (!stall_out) begin
            wb_valid_d = ex_valid_q;
            wb_data_d  = (ex_mr_q & ~ex_mw_q) ? mem_rdata : ex_aluout_q;
            wb_dst_d   = ex_dst_q;
            wb_rw_d    = ex_valid_q & ex_rw_q;
        end
    end

    // A ready arriving in the timeout cycle still completes the access.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !mem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == MAX_W) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            ex_valid_q  <= 1'b0;
            ex_aluout_q <= 16'h0000;
            ex_store_q  <= 16'h0000;
            ex_dst_q    <= 4'h0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 16'h0000;
            wb_dst_q    <= 4'h0;
            wb_rw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_aluout_q <= ex_aluout_d;
            ex_store_q  <= ex_store_d;
            ex_dst_q    <= ex_dst_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_mw_q     <= ex_mw_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dst_q    <= wb_dst_d;
            wb_rw_q     <= wb_rw_d;
        end
    end

endmodule

// File: tb/tb_mod_mem.sv
// Directed testbench for mod_mem with MAX_WAIT=4.
module tb_mod_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] aluout;
    logic [15:0] store_data;
    logic [3:0]  dstreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] forward_DstData_MEM;
    logic [3:0]  fwd_dstreg;
    logic        fwd_regwrite;
    logic        wb_valid;
    logic [15:0] wb_DstData;
    logic [3:0]  wb_dstreg;
    logic        wb_regwrite;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_mem #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .aluout(aluout), .store_data(store_data),
        .dstreg(dstreg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .forward_DstData_MEM(forward_DstData_MEM),
        .fwd_dstreg(fwd_dstreg), .fwd_regwrite(fwd_regwrite),
        .wb_valid(wb_valid), .wb_DstData(wb_DstData),
        .wb_dstreg(wb_dstreg), .wb_regwrite(wb_regwrite),
        .mem_err(mem_err)
    );

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] sd, input logic [3:0] d,
                         input logic rw, input logic mr, input logic mw);
        in_valid   = v;
        aluout     = a;
        store_data = sd;
        dstreg     = d;
        regwrite   = rw;
        memread    = mr;
        memwrite   = mw;
    endtask

    task automatic bubble();
        drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        bubble();
        edge1();
        edge1();
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_out); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", mem_req); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wbv got %b want 0", wb_valid); end
        n_cmp++; if (wb_DstData !== 16'h0) begin n_bad++; $display("FAIL rst_wbd got %h want 0", wb_DstData); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", mem_err); end
        n_cmp++; if (fwd_regwrite !== 1'b0) begin n_bad++; $display("FAIL rst_fwr got %b want 0", fwd_regwrite); end
        #2 rst = 1'b1;
        edge1();
    endtask

    task automatic test_add();
        drive(1'b1, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
        edge1();
        bubble();
        #1;
        n_cmp++; if (forward_DstData_MEM !== 16'h1234) begin n_bad++; $display("FAIL add_fwd got %h want 1234", forward_DstData_MEM); end
        n_cmp++; if (fwd_dstreg !== 4'd3) begin n_bad++; $display("FAIL add_ftag got %0d want 3", fwd_dstreg); end
        n_cmp++; if (fwd_regwrite !== 1'b1) begin n_bad++; $display("FAIL add_fwr got %b want 1", fwd_regwrite); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL add_stall got %b want 0", stall_out); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL add_req got %b want 0", mem_req); end
        edge1();
        n_cmp++; if (wb_DstData !== 16'h1234) begin n_bad++; $display("FAIL add_wbd got %h want 1234", wb_DstData); end
        n_cmp++; if (wb_dstreg !== 4'd3) begin n_bad++; $display("FAIL add_wbtag got %0d want 3", wb_dstreg); end
        n_cmp++; if (wb_regwrite !== 1'b1) begin n_bad++; $display("FAIL add_wbrw got %b want 1", wb_regwrite); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL add_wbv got %b want 1", wb_valid); end
        edge1();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL add_drain got %b want 0", wb_valid); end
    endtask

    task automatic test_lw_zero_wait();
        drive(1'b1, 16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0);
        edge1();
        bubble();
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL lw_req got %b want 1", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 16'h0040) begin n_bad++; $display("FAIL lw_addr got %h want 0040", mem_addr); end
        n_cmp++; if (fwd_regwrite !== 1'b0) begin n_bad++; $display("FAIL lw_fwr got %b want 0", fwd_regwrite); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL lw_stall got %b want 0", stall_out); end
        edge1();
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        n_cmp++; if (wb_DstData !== 16'hBEEF) begin n_bad++; $display("FAIL lw_wbd got %h want beef", wb_DstData); end
        n_cmp++; if (wb_dstreg !== 4'd5) begin n_bad++; $display("FAIL lw_wbtag got %0d want 5", wb_dstreg); end
        n_cmp++; if (wb_regwrite !== 1'b1) begin n_bad++; $display("FAIL lw_wbrw got %b want 1", wb_regwrite); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_off got %b want 0", mem_req); end
    endtask

    task automatic test_sw_wait();
        drive(1'b1, 16'h0010, 16'h00AA, 4'd0, 1'b0, 1'b0, 1'b1);
        edge1();
        drive(1'b1, 16'h5555, 16'h0, 4'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL sw_stall%0d got %b want 1", i, stall_out); end
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_bad++; $display("FAIL sw_req%0d got %b%b want 11", i, mem_req, mem_we); end
            n_cmp++; if (mem_addr !== 16'h0010 || mem_wdata !== 16'h00AA) begin n_bad++; $display("FAIL sw_bus%0d got %h/%h want 0010/00aa", i, mem_addr, mem_wdata); end
            n_cmp++; if (forward_DstData_MEM !== 16'h0010) begin n_bad++; $display("FAIL sw_hold%0d got %h want 0010", i, forward_DstData_MEM); end
            edge1();
            n_cmp++; if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin n_bad++; $display("FAIL sw_wbbub%0d got %b%b want 00", i, wb_valid, wb_regwrite); end
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL sw_done_stall got %b want 0", stall_out); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL sw_err got %b want 0", mem_err); end
        edge1();
        mem_ready = 1'b0;
        bubble();
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL sw_wbv got %b want 1", wb_valid); end
        n_cmp++; if (wb_regwrite !== 1'b0) begin n_bad++; $display("FAIL sw_wbrw got %b want 0", wb_regwrite); end
        n_cmp++; if (wb_DstData !== 16'h0010) begin n_bad++; $display("FAIL sw_wbd got %h want 0010", wb_DstData); end
        n_cmp++; if (forward_DstData_MEM !== 16'h5555) begin n_bad++; $display("FAIL sw_next got %h want 5555", forward_DstData_MEM); end
        edge1();
        n_cmp++; if (wb_DstData !== 16'h5555 || wb_dstreg !== 4'd7) begin n_bad++; $display("FAIL sw_nextwb got %h/%0d want 5555/7", wb_DstData, wb_dstreg); end
    endtask

    task automatic test_priority();
        drive(1'b1, 16'h0050, 16'h0077, 4'd6, 1'b1, 1'b1, 1'b1);
        edge1();
        bubble();
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL pri_we got %b want 1", mem_we); end
        edge1();
        mem_ready = 1'b0;
        n_cmp++; if (wb_DstData !== 16'h0050) begin n_bad++; $display("FAIL pri_wbd got %h want 0050", wb_DstData); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h1111, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0);
        edge1();
        drive(1'b1, 16'h2222, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
        edge1();
        bubble();
        n_cmp++; if (wb_DstData !== 16'h1111 || wb_dstreg !== 4'd1) begin n_bad++; $display("FAIL b2b_a got %h/%0d want 1111/1", wb_DstData, wb_dstreg); end
        edge1();
        n_cmp++; if (wb_DstData !== 16'h2222 || wb_dstreg !== 4'd2) begin n_bad++; $display("FAIL b2b_b got %h/%0d want 2222/2", wb_DstData, wb_dstreg); end
    endtask

    task automatic test_timeout();
        drive(1'b1, 16'h0020, 16'h0, 4'd2, 1'b1, 1'b1, 1'b0);
        edge1();
        bubble();
        for (int i = 0; i < 4; i++) edge1();
        n_cmp++; if (mem_err !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL to_pre got err=%b req=%b want 0/1", mem_err, mem_req); end
        edge1();
        n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", mem_err); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL to_req got %b want 0", mem_req); end
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL to_stall got %b want 1", stall_out); end
        mem_ready = 1'b1;
        edge1();
        mem_ready = 1'b0;
        edge1();
        n_cmp++; if (mem_err !== 1'b1 || stall_out !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b%b want 11", mem_err, stall_out); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL to_wbv got %b want 0", wb_valid); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_err !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b%b want 00", mem_err, stall_out); end
        #2 rst = 1'b1;
        edge1();
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 16'h0030, 16'h0099, 4'd0, 1'b0, 1'b0, 1'b1);
        edge1();
        bubble();
        edge1();
        n_cmp++; if (stall_out !== 1'b1 || mem_req !== 1'b1) begin n_bad++; $display("FAIL rw_pre got %b%b want 11", stall_out, mem_req); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL rw_async got %b%b want 00", mem_req, stall_out); end
        n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rw_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (wb_valid !== 1'b0 || forward_DstData_MEM !== 16'h0) begin n_bad++; $display("FAIL rw_regs got %b/%h want 0/0", wb_valid, forward_DstData_MEM); end
        #2 rst = 1'b1;
        drive(1'b1, 16'h0ABC, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0);
        edge1();
        bubble();
        edge1();
        n_cmp++; if (wb_DstData !== 16'h0ABC || wb_regwrite !== 1'b1) begin n_bad++; $display("FAIL rw_add got %h/%b want 0abc/1", wb_DstData, wb_regwrite); end
    endtask

    task automatic test_bubble_ready();
        bubble();
        edge1();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            mem_rdata = 16'hCAFE;
            #1;
            n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL bub_req%0d got %b%b want 00", i, mem_req, stall_out); end
            edge1();
            mem_ready = 1'b0;
            n_cmp++; if (wb_valid !== 1'b0 || wb_DstData !== 16'h0) begin n_bad++; $display("FAIL bub_wb%0d got %b/%h want 0/0", i, wb_valid, wb_DstData); end
        end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL bub_err got %b want 0", mem_err); end
        drive(1'b1, 16'h0060, 16'h0, 4'd9, 1'b1, 1'b1, 1'b0);
        edge1();
        bubble();
        mem_ready = 1'b1;
        mem_rdata = 16'h4321;
        #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL bub_lw_stall got %b want 0", stall_out); end
        edge1();
        mem_ready = 1'b0;
        n_cmp++; if (wb_DstData !== 16'h4321) begin n_bad++; $display("FAIL bub_lw_wbd got %h want 4321", wb_DstData); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_zero_wait();
        test_sw_wait();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_wait();
        test_bubble_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
